// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage instruction fields in, forwarding/stall decisions out
interface fwd_hazard_unit_if #(
  parameter int AW = 5,
  parameter int SW = 2,
  parameter int CW = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [AW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_is_load;
  logic          flush;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic          id_byp_rs;
  logic          id_byp_rt;
  logic          stall;
  logic [CW-1:0] stall_cnt;
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_reg_write, id_is_load, flush,
    input  fwd_a, fwd_b, id_byp_rs, id_byp_rt, stall, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_reg_write, id_is_load, flush,
    output fwd_a, fwd_b, id_byp_rs, id_byp_rt, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: in-flight write scoreboard driving EX forwarding, ID bypass and load-use stall
module fwd_hazard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 16,
  parameter int SW       = $clog2(DEPTH)
) (
  input logic Clk,
  input logic Reset,
  fwd_hazard_unit_if.slave bus
);
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          rw;
    logic          ld;
  } slot_t;
  slot_t         slot [DEPTH];
  logic [AW-1:0] ex_rs, ex_rt;
  logic [DEPTH-1:0] wr;
  logic          hz_rs, hz_rt, issue;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) wr[i] = slot[i].v & slot[i].rw & (slot[i].rd != '0);
  end
  // Descending scans: the last hit is the youngest matching slot.
  always_comb begin
    bus.fwd_a = '0;
    bus.fwd_b = '0;
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (wr[k] && slot[k].rd == ex_rs && ex_rs != '0) bus.fwd_a = SW'(k);
      if (wr[k] && slot[k].rd == ex_rt && ex_rt != '0) bus.fwd_b = SW'(k);
    end
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (wr[j] && slot[j].rd == bus.id_rs) hz_rs = slot[j].ld && j < LOAD_LAT;
      if (wr[j] && slot[j].rd == bus.id_rt) hz_rt = slot[j].ld && j < LOAD_LAT;
    end
    hz_rs = hz_rs & bus.id_use_rs & (bus.id_rs != '0);
    hz_rt = hz_rt & bus.id_use_rt & (bus.id_rt != '0);
    bus.id_byp_rs = wr[DEPTH-1] && slot[DEPTH-1].rd == bus.id_rs && bus.id_rs != '0;
    bus.id_byp_rt = wr[DEPTH-1] && slot[DEPTH-1].rd == bus.id_rt && bus.id_rt != '0;
  end
  assign bus.stall = bus.id_valid & ~bus.flush & (hz_rs | hz_rt);
  assign issue     = bus.id_valid & ~bus.stall & ~bus.flush;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      bus.stall_cnt <= '0;
    end else begin
      slot[0] <= issue ? slot_t'({1'b1, bus.id_rd, bus.id_reg_write, bus.id_is_load}) : slot_t'('0);
      for (int i = 1; i < DEPTH; i++) slot[i] <= slot[i-1];
      ex_rs <= (issue && bus.id_use_rs) ? bus.id_rs : '0;
      ex_rt <= (issue && bus.id_use_rt) ? bus.id_rt : '0;
      if (bus.stall && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors checked against an age-based scoreboard model every cycle
module tb_fwd_hazard_unit;
  localparam int AW = 5, DEPTH = 3, LL = 1, CW = 16, SW = $clog2(DEPTH), MAXC = 512;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  fwd_hazard_unit_if #(.AW(AW), .SW(SW), .CW(CW)) bus ();
  fwd_hazard_unit_if #(.AW(AW), .SW(SW), .CW(2))  bus2 ();
  assign bus2.id_valid     = bus.id_valid;
  assign bus2.id_rs        = bus.id_rs;
  assign bus2.id_rt        = bus.id_rt;
  assign bus2.id_use_rs    = bus.id_use_rs;
  assign bus2.id_use_rt    = bus.id_use_rt;
  assign bus2.id_rd        = bus.id_rd;
  assign bus2.id_reg_write = bus.id_reg_write;
  assign bus2.id_is_load   = bus.id_is_load;
  assign bus2.flush        = bus.flush;

  fwd_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LL), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave));
  fwd_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LL), .CW(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(bus2.slave));

  int vecs = 0, miss = 0;
  int n = 0, last_rst = -1, mcnt = 0;
  bit armed = 1'b0;
  bit i_v [MAXC];
  bit i_rw [MAXC];
  bit i_ld [MAXC];
  int i_rd [MAXC];
  int i_rs [MAXC];
  int i_rt [MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n);
    end
  endtask

  // Instruction issued at cycle idx, still in flight, writing nonzero register r.
  function automatic bit writer(input int idx, input int r);
    if (idx < 0 || idx <= last_rst) return 1'b0;
    return i_v[idx] && i_rw[idx] && i_rd[idx] != 0 && i_rd[idx] == r;
  endfunction

  function automatic bit hazard(input bit use_r, input int r);
    if (!use_r || r == 0) return 1'b0;
    for (int age = 0; age <= DEPTH - 2; age++)
      if (writer(n - 1 - age, r)) return i_ld[n - 1 - age] && age < LL;
    return 1'b0;
  endfunction

  function automatic int fwd_src(input int r);
    if (r == 0) return 0;
    for (int age = 1; age < DEPTH; age++)
      if (writer(n - 1 - age, r)) return age;
    return 0;
  endfunction

  always @(negedge Clk) begin
    int ers, ert, ea, eb, st, iss;
    ers = 0;
    ert = 0;
    if (n >= 1 && n - 1 > last_rst) begin
      ers = i_rs[n-1];
      ert = i_rt[n-1];
    end
    ea = fwd_src(ers);
    eb = fwd_src(ert);
    st = bus.id_valid && !bus.flush &&
         (hazard(bus.id_use_rs, int'(bus.id_rs)) || hazard(bus.id_use_rt, int'(bus.id_rt)));
    if (armed) begin
      chk("fwd_a", 32'(bus.fwd_a), ea);
      chk("fwd_b", 32'(bus.fwd_b), eb);
      chk("stall", 32'(bus.stall), st);
      chk("id_byp_rs", 32'(bus.id_byp_rs), int'(bus.id_rs != 0 && writer(n - DEPTH, int'(bus.id_rs))));
      chk("id_byp_rt", 32'(bus.id_byp_rt), int'(bus.id_rt != 0 && writer(n - DEPTH, int'(bus.id_rt))));
      chk("stall_cnt", 32'(bus.stall_cnt), mcnt > 65535 ? 65535 : mcnt);
      chk("stall_cnt_cw2", 32'(bus2.stall_cnt), mcnt > 3 ? 3 : mcnt);
      vecs++;
      assert ((ea == 0 || !i_ld[n-1-ea] || ea >= 1 + LL) && (eb == 0 || !i_ld[n-1-eb] || eb >= 1 + LL))
      else begin
        miss++;
        $display("FAIL ready: forwarded slot not ready fwd_a=%0d fwd_b=%0d", ea, eb);
      end
    end
    iss = bus.id_valid && !st && !bus.flush && !Reset;
    if (n < MAXC) begin
      i_v[n]  = iss != 0;
      i_rd[n] = iss ? int'(bus.id_rd) : 0;
      i_rw[n] = iss != 0 && bus.id_reg_write;
      i_ld[n] = iss != 0 && bus.id_is_load;
      i_rs[n] = (iss != 0 && bus.id_use_rs) ? int'(bus.id_rs) : 0;
      i_rt[n] = (iss != 0 && bus.id_use_rt) ? int'(bus.id_rt) : 0;
    end
    if (Reset) begin
      last_rst = n;
      mcnt = 0;
      armed = 1'b1;
    end else if (st != 0) mcnt++;
    n++;
  end

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int rd, input bit rw, input bit ld, input bit fl, input bit r = 1'b0);
    @(posedge Clk);
    #1;
    Reset = r;
    bus.id_valid = v;
    bus.id_rs = AW'(rs);
    bus.id_rt = AW'(rt);
    bus.id_use_rs = urs;
    bus.id_use_rt = urt;
    bus.id_rd = AW'(rd);
    bus.id_reg_write = rw;
    bus.id_is_load = ld;
    bus.flush = fl;
    @(negedge Clk);
  endtask

  task automatic nop(input bit r = 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  initial begin
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_rd = 0; bus.id_reg_write = 0; bus.id_is_load = 0; bus.flush = 0;
    nop(1); nop(1);
    chk("reset_fwd_a", 32'(bus.fwd_a), 0);
    chk("reset_stall_cnt", 32'(bus.stall_cnt), 0);
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
    drive(1, 3, 0, 1, 0, 6, 1, 0, 0);
    chk("alu_use_no_stall", 32'(bus.stall), 0);
    drive(1, 3, 0, 1, 0, 8, 1, 0, 0);
    chk("fwd_a_mem", 32'(bus.fwd_a), 1);
    nop();
    chk("fwd_a_wb", 32'(bus.fwd_a), 2);
    drive(1, 1, 0, 1, 0, 4, 1, 1, 0);
    drive(1, 2, 4, 1, 1, 0, 0, 0, 0);
    chk("load_use_stall", 32'(bus.stall), 1);
    drive(1, 2, 4, 1, 1, 0, 0, 0, 0);
    chk("stall_one_cycle", 32'(bus.stall), 0);
    chk("stall_cnt_1", 32'(bus.stall_cnt), 1);
    nop();
    chk("store_fwd_b", 32'(bus.fwd_b), 2);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    drive(1, 5, 0, 1, 0, 9, 1, 0, 0);
    nop();
    chk("youngest_wins", 32'(bus.fwd_a), 1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 9, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0);
    chk("r0_no_fwd", 32'(bus.fwd_a), 0);
    drive(1, 0, 10, 0, 0, 11, 1, 0, 0);
    nop();
    chk("unused_rt_no_fwd", 32'(bus.fwd_b), 0);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
    nop(); nop();
    drive(1, 7, 7, 1, 1, 0, 0, 0, 0);
    chk("byp_rs", 32'(bus.id_byp_rs), 1);
    chk("byp_rt", 32'(bus.id_byp_rt), 1);
    drive(1, 1, 0, 1, 0, 12, 1, 1, 0);
    drive(1, 12, 0, 1, 0, 13, 1, 0, 1);
    chk("flush_beats_stall", 32'(bus.stall), 0);
    nop();
    chk("flush_bubble", 32'(bus.fwd_a), 0);
    drive(1, 1, 0, 1, 0, 13, 1, 1, 0);
    drive(1, 13, 0, 1, 0, 14, 1, 0, 0, 1);
    chk("stall_before_reset", 32'(bus.stall), 1);
    drive(1, 13, 0, 1, 0, 14, 1, 0, 0);
    chk("post_reset_stall", 32'(bus.stall), 0);
    chk("post_reset_cnt", 32'(bus.stall_cnt), 0);
    chk("post_reset_fwd_a", 32'(bus.fwd_a), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 0, 15 + i, 1, 1, 0);
      drive(1, 15 + i, 0, 1, 0, 20, 1, 0, 0);
      drive(1, 15 + i, 0, 1, 0, 20, 1, 0, 0);
    end
    nop();
    chk("cnt_five", 32'(bus.stall_cnt), 5);
    chk("cnt_saturate", 32'(bus2.stall_cnt), 3);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
